pointer_collision: RTL and testbench
====================================

# pointer_collision

Receiving end of the obstacle coordinate bus. Obstacle drawing modules emit the screen coordinates of every obstacle pixel they draw, and zero when not drawing. This block compares those coordinates against the mouse-pointer hitbox, tracks player HP with per-frame invulnerability after each hit, and raises `game_over`. It sits beside the obstacle chain and feeds the game-flow controller and HUD.

## Interface
- `HP_MAX`, 5: HP loaded on entering a game; range 1..15.
- `CURSOR_W`, 16: hitbox width in pixels, measured from `mouse_x`.
- `CURSOR_H`, 16: hitbox height in pixels, measured from `mouse_y`.
- `COOLDOWN_FRAMES`, 60: invulnerability length in frames after a hit; must be ≥1.

Ports:
- `clk`  in  1  pixel clock
- `rst`  in  1  reset, synchronous, active-high
- `hcount_in`  in  12  current pixel column
- `vcount_in`  in  12  current pixel line
- `obstacle_x`  in  12  obstacle pixel x; this is the OR of all obstacle modules' outputs
- `obstacle_y`  in  12  obstacle pixel y; same OR
- `mouse_x`  in  12  pointer x, asynchronous to the frame
- `mouse_y`  in  12  pointer y
- `play_selected`  in  1  game running
- `menu_on`  in  1  menu displayed
- `hp`  out  4  remaining HP
- `hit`  out  1  one-cycle pulse per registered hit
- `invulnerable`  out  1  high during cooldown
- `game_over`  out  1  high while in DEAD

## Operation
- Frame tick: high when `hcount_in==0 && vcount_in==0`.
- Pointer latch:
  - `mouse_x`/`mouse_y` are captured into `mx_r`/`my_r` on frame tick only. The hitbox stays constant for a whole frame.
  - Reset value of both latches is 0.
- Obstacle pixel valid: `obstacle_x!=0 || obstacle_y!=0`. A pixel at (0,0) is never a collision.
- Collision condition: pixel valid, `mx_r ≤ obstacle_x ≤ mx_r+CURSOR_W-1`, and `my_r ≤ obstacle_y ≤ my_r+CURSOR_H-1`.
  - Sums are computed 13 bits wide, so a hitbox near 4095 does not wrap.
- States:
  - IDLE:
    - `hp=HP_MAX`, all flags 0.
    - Go to ARMED when `play_selected && !menu_on`.
  - ARMED, on collision:
    - `hit` pulses and `hp` decrements.
    - If `hp==1`, go to DEAD with `hp` reaching 0.
    - Otherwise go to COOLDOWN and load the cooldown counter with `COOLDOWN_FRAMES`.
  - COOLDOWN:
    - `invulnerable=1`; collisions are ignored.
    - The counter decrements on each frame tick.
    - On the frame tick where the counter is 1, go to ARMED.
  - DEAD:
    - `game_over=1` and `hp=0`; collisions are ignored.
    - Go to IDLE when `menu_on` is high or `play_selected` is low.
- Abort: in ARMED or COOLDOWN, `menu_on || !play_selected` sends the block to IDLE. Abort has priority over a same-cycle collision, and no hit is recorded.
- HP can never underflow; it saturates at 0 in DEAD.

## Timing
- Reset values: state IDLE, `hp=HP_MAX`, `hit=0`, `invulnerable=0`, `game_over=0`, cooldown counter 0, `mx_r`/`my_r` 0.
- Outputs are registered.
- Collision latency:
  - A colliding pixel on the bus at cycle n produces `hit=1` and the new `hp` at cycle n+1.
  - `invulnerable` or `game_over` rises at n+1.
- Only one hit per collision episode. Further colliding pixels in the same frame fall into COOLDOWN and are ignored.
- Cooldown length: the first frame tick after the hit counts as frame 1. ARMED resumes on the cycle after the `COOLDOWN_FRAMES`-th tick.
- Reset mid-game: returns to IDLE next edge and reloads HP. No hit pulse is produced on the reset cycle.
- Frame tick and collision in the same cycle:
  - Collision uses the old `mx_r`/`my_r`.
  - In COOLDOWN, the tick's decrement happens and the collision is ignored.

## Structure
- `game_pkg` holds the state encodings (IDLE/ARMED/COOLDOWN/DEAD, 2 bits), `HP_W=4`, and the screen-coordinate width `COORD_W=12`.
- Sub-module `hitbox_compare`: combinational pixel-valid plus 13-bit range compare, parameterised by `CURSOR_W`/`CURSOR_H`.
- Top level holds the FSM, frame-tick detect, pointer latch, cooldown counter and HP register.

## Test plan
- Reset, then `play_selected=1`, `menu_on=0` → ARMED next cycle, `hp=5`, all flags 0.
- Pointer latched at (400,300); drive obstacle pixel (410,310) → `hit` pulse one cycle later, `hp=4`, `invulnerable=1`. Pixel (416,300) → no hit (edge exclusive).
- During cooldown, drive colliding pixels every frame → `hp` stays 4. After the 60th frame tick the state is ARMED, and the next colliding pixel gives `hp=3`.
- Five hits separated by cooldowns → `hp=0`, `game_over=1`. Further collisions do nothing. Then `menu_on=1` → IDLE, `hp=5`.
- Change `mouse_x` mid-frame from 400 to 100, pixel at (410,310) → hit still registered. After the next frame tick the same pixel gives no hit.
- `menu_on` and a colliding pixel in the same cycle in ARMED → IDLE, no `hit`, `hp=5`. Obstacle bus (0,0) with pointer at (0,0) → no hit.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the obstacle-collision logic.
// Holds the FSM state encodings, the HP register width and the screen-coordinate width.
// No ports; imported by hitbox_compare and pointer_collision.
package game_pkg;

  localparam int COORD_W = 12;
  localparam int HP_W    = 4;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ARMED    = 2'd1;
  localparam logic [1:0] ST_COOLDOWN = 2'd2;
  localparam logic [1:0] ST_DEAD     = 2'd3;

endpackage

// File: rtl/hitbox_compare.sv
// Combinational test of one obstacle pixel against the pointer hitbox.
// Ports: obstacle_x/obstacle_y pixel from the obstacle bus, box_x/box_y latched
// hitbox origin, collide high when the pixel is valid and inside the box.
module hitbox_compare
  import game_pkg::*;
#(
  parameter int CURSOR_W = 16,
  parameter int CURSOR_H = 16
) (
  input  logic [COORD_W-1:0] obstacle_x,
  input  logic [COORD_W-1:0] obstacle_y,
  input  logic [COORD_W-1:0] box_x,
  input  logic [COORD_W-1:0] box_y,
  output logic               collide
);

  localparam logic [COORD_W:0] W_OFF = (COORD_W+1)'(CURSOR_W - 1);
  localparam logic [COORD_W:0] H_OFF = (COORD_W+1)'(CURSOR_H - 1);

  // One extra bit on every operand so a box near the right/bottom screen
  // edge extends past 4095 instead of wrapping to small coordinates.
  logic [COORD_W:0] ox, oy, x_lo, y_lo, x_hi, y_hi;
  logic             pix_valid, in_x, in_y;

  assign ox   = {1'b0, obstacle_x};
  assign oy   = {1'b0, obstacle_y};
  assign x_lo = {1'b0, box_x};
  assign y_lo = {1'b0, box_y};
  assign x_hi = x_lo + W_OFF;
  assign y_hi = y_lo + H_OFF;

  // The bus idles at (0,0), so that coordinate can never be a real pixel.
  assign pix_valid = (obstacle_x != '0) || (obstacle_y != '0);
  assign in_x      = (ox >= x_lo) && (ox <= x_hi);
  assign in_y      = (oy >= y_lo) && (oy <= y_hi);
  assign collide   = pix_valid && in_x && in_y;

endmodule

// File: rtl/pointer_collision.sv
// Collision detection between the obstacle coordinate bus and the mouse hitbox,
// with HP tracking, per-frame invulnerability after a hit and game-over flag.
// Ports: clk/rst, raster position, obstacle bus, mouse position, game-flow
// inputs (play_selected, menu_on); registered outputs hp, hit, invulnerable, game_over.
module pointer_collision
  import game_pkg::*;
#(
  parameter int HP_MAX          = 5,
  parameter int CURSOR_W        = 16,
  parameter int CURSOR_H        = 16,
  parameter int COOLDOWN_FRAMES = 60
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] hcount_in,
  input  logic [COORD_W-1:0] vcount_in,
  input  logic [COORD_W-1:0] obstacle_x,
  input  logic [COORD_W-1:0] obstacle_y,
  input  logic [COORD_W-1:0] mouse_x,
  input  logic [COORD_W-1:0] mouse_y,
  input  logic               play_selected,
  input  logic               menu_on,
  output logic [HP_W-1:0]    hp,
  output logic               hit,
  output logic               invulnerable,
  output logic               game_over
);

  localparam int            CNT_W   = $clog2(COOLDOWN_FRAMES + 1);
  localparam logic [HP_W-1:0] HP_FULL = HP_W'(HP_MAX);

  logic [1:0]         state;
  logic [CNT_W-1:0]   cool_cnt;
  logic [COORD_W-1:0] mx_r, my_r;
  logic               frame_tick, collide, abort;

  assign frame_tick = (hcount_in == '0) && (vcount_in == '0);
  assign abort      = menu_on || !play_selected;

  // Uses the latched pointer, so a tick-cycle pixel is judged against the
  // previous frame's hitbox.
  hitbox_compare #(
    .CURSOR_W (CURSOR_W),
    .CURSOR_H (CURSOR_H)
  ) u_hitbox (
    .obstacle_x (obstacle_x),
    .obstacle_y (obstacle_y),
    .box_x      (mx_r),
    .box_y      (my_r),
    .collide    (collide)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      hp       <= HP_FULL;
      hit      <= 1'b0;
      cool_cnt <= '0;
      mx_r     <= '0;
      my_r     <= '0;
    end else begin
      hit <= 1'b0;

      // The pointer is asynchronous to the raster; freezing it per frame
      // keeps the hitbox stable while the obstacles are being drawn.
      if (frame_tick) begin
        mx_r <= mouse_x;
        my_r <= mouse_y;
      end

      case (state)
        ST_IDLE: begin
          hp       <= HP_FULL;
          cool_cnt <= '0;
          if (!abort) state <= ST_ARMED;
        end
        ST_ARMED: begin
          if (abort) begin
            state <= ST_IDLE;
            hp    <= HP_FULL;
          end else if (collide) begin
            hit <= 1'b1;
            hp  <= hp - HP_W'(1);
            if (hp == HP_W'(1)) begin
              state <= ST_DEAD;
            end else begin
              state    <= ST_COOLDOWN;
              cool_cnt <= CNT_W'(COOLDOWN_FRAMES);
            end
          end
        end
        ST_COOLDOWN: begin
          if (abort) begin
            state    <= ST_IDLE;
            hp       <= HP_FULL;
            cool_cnt <= '0;
          end else if (frame_tick) begin
            cool_cnt <= cool_cnt - CNT_W'(1);
            if (cool_cnt == CNT_W'(1)) state <= ST_ARMED;
          end
        end
        ST_DEAD: begin
          hp <= '0;
          if (abort) begin
            state <= ST_IDLE;
            hp    <= HP_FULL;
          end
        end
        default: begin
          state <= ST_IDLE;
          hp    <= HP_FULL;
        end
      endcase
    end
  end

  // Straight decodes of the state register, so these still change only on clk.
  assign invulnerable = (state == ST_COOLDOWN);
  assign game_over    = (state == ST_DEAD);

endmodule

// File: tb/tb_pointer_collision.sv
module tb_pointer_collision;

  localparam int HPMAX = 5;
  localparam int CW    = 16;
  localparam int CH    = 16;
  localparam int CD    = 60;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] hcount_in = 12'd5, vcount_in = 12'd5;
  logic [11:0] obstacle_x = '0, obstacle_y = '0;
  logic [11:0] mouse_x = '0, mouse_y = '0;
  logic        play_selected = 1'b0, menu_on = 1'b0;
  logic [3:0]  hp;
  logic        hit, invulnerable, game_over;

  pointer_collision #(
    .HP_MAX(HPMAX), .CURSOR_W(CW), .CURSOR_H(CH), .COOLDOWN_FRAMES(CD)
  ) dut (
    .clk(clk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .obstacle_x(obstacle_x), .obstacle_y(obstacle_y),
    .mouse_x(mouse_x), .mouse_y(mouse_y),
    .play_selected(play_selected), .menu_on(menu_on),
    .hp(hp), .hit(hit), .invulnerable(invulnerable), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Reference model: "in a game or not", lives left, frames of protection left.
  bit in_game = 0;
  int m_hp    = HPMAX;
  int cool    = 0;
  int lx = 0, ly = 0;
  bit m_hit   = 0;

  task automatic model_step();
    bit tk;
    bit coll;
    tk   = (hcount_in == 0) && (vcount_in == 0);
    coll = (obstacle_x != 0 || obstacle_y != 0) &&
           int'(obstacle_x) >= lx && int'(obstacle_x) < lx + CW &&
           int'(obstacle_y) >= ly && int'(obstacle_y) < ly + CH;
    m_hit = 0;
    if (rst) begin
      in_game = 0; m_hp = HPMAX; cool = 0; lx = 0; ly = 0;
    end else begin
      if (!in_game) begin
        if (play_selected && !menu_on) in_game = 1;
      end else if (menu_on || !play_selected) begin
        in_game = 0; m_hp = HPMAX; cool = 0;
      end else if (m_hp == 0) begin
        // dead: nothing happens until the player leaves the game
      end else if (cool > 0) begin
        if (tk) cool = cool - 1;
      end else if (coll) begin
        m_hit = 1;
        m_hp  = m_hp - 1;
        if (m_hp > 0) cool = CD;
      end
      if (tk) begin lx = mouse_x; ly = mouse_y; end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_bus();
    hcount_in = 12'd5; vcount_in = 12'd5; obstacle_x = 0; obstacle_y = 0;
  endtask

  task automatic frame_tick();
    hcount_in = 0; vcount_in = 0; obstacle_x = 0; obstacle_y = 0;
    cycle();
    idle_bus();
  endtask

  task automatic pixel(input int x, input int y);
    obstacle_x = 12'(x); obstacle_y = 12'(y);
    cycle();
    obstacle_x = 0; obstacle_y = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle_bus(); cycle(); cycle();
    checks++; if (hp !== 4'd5) $display("FAIL reset_hp got=%0d exp=5", hp); else passed++;
    checks++;
    if ({hit, invulnerable, game_over} !== 3'b000)
      $display("FAIL reset_flags got=%b exp=000", {hit, invulnerable, game_over});
    else passed++;
    rst = 0;
    play_selected = 1; menu_on = 0; cycle();
    checks++;
    if (hp !== 4'd5 || {hit, invulnerable, game_over} !== 3'b000)
      $display("FAIL arm got hp=%0d flags=%b exp hp=5 flags=000", hp, {hit, invulnerable, game_over});
    else passed++;
  endtask

  task automatic test_first_hit();
    mouse_x = 400; mouse_y = 300; frame_tick();
    pixel(416, 300);
    checks++;
    if (hit !== 1'b0 || hp !== 4'd5) $display("FAIL edge_excl got hit=%b hp=%0d exp hit=0 hp=5", hit, hp);
    else passed++;
    pixel(410, 310);
    checks++;
    if (hit !== 1'b1 || hp !== 4'd4 || invulnerable !== 1'b1)
      $display("FAIL first_hit got hit=%b hp=%0d inv=%b exp 1/4/1", hit, hp, invulnerable);
    else passed++;
    cycle();
    checks++; if (hit !== 1'b0) $display("FAIL hit_pulse got=%b exp=0", hit); else passed++;
  endtask

  task automatic test_cooldown();
    for (int f = 1; f <= CD; f++) begin
      frame_tick();
      checks++;
      if (invulnerable !== (f < CD))
        $display("FAIL cool_inv frame=%0d got=%b exp=%b", f, invulnerable, (f < CD));
      else passed++;
      pixel(410, 310);
      checks++;
      if (hp !== 4'(m_hp) || hp !== ((f < CD) ? 4'd4 : 4'd3))
        $display("FAIL cool_hp frame=%0d got=%0d exp=%0d", f, hp, (f < CD) ? 4 : 3);
      else passed++;
    end
  endtask

  task automatic test_death();
    for (int h = 0; h < 3; h++) begin
      for (int f = 0; f < CD; f++) frame_tick();
      pixel(405, 305);
    end
    checks++;
    if (hp !== 4'd0 || game_over !== 1'b1 || hit !== 1'b1)
      $display("FAIL death got hp=%0d go=%b hit=%b exp 0/1/1", hp, game_over, hit);
    else passed++;
    frame_tick(); pixel(410, 310); pixel(400, 300);
    checks++;
    if (hp !== 4'd0 || hit !== 1'b0 || game_over !== 1'b1)
      $display("FAIL dead_ignore got hp=%0d hit=%b go=%b exp 0/0/1", hp, hit, game_over);
    else passed++;
    menu_on = 1; cycle();
    checks++;
    if (hp !== 4'd5 || game_over !== 1'b0) $display("FAIL dead_exit got hp=%0d go=%b exp 5/0", hp, game_over);
    else passed++;
    menu_on = 0; cycle();
  endtask

  task automatic test_mouse_latch();
    mouse_x = 400; mouse_y = 300; frame_tick();
    mouse_x = 100; cycle();
    pixel(410, 310);
    checks++;
    if (hit !== 1'b1 || hp !== 4'd4) $display("FAIL latch_hold got hit=%b hp=%0d exp 1/4", hit, hp);
    else passed++;
    menu_on = 1; cycle(); menu_on = 0; cycle();
    frame_tick();
    pixel(410, 310);
    checks++;
    if (hit !== 1'b0 || hp !== 4'd5) $display("FAIL latch_new got hit=%b hp=%0d exp 0/5", hit, hp);
    else passed++;
    pixel(105, 310);
    checks++;
    if (hit !== 1'b1 || hp !== 4'd4) $display("FAIL latch_new_hit got hit=%b hp=%0d exp 1/4", hit, hp);
    else passed++;
  endtask

  task automatic test_abort();
    play_selected = 0; cycle(); play_selected = 1; cycle();
    mouse_x = 400; mouse_y = 300; frame_tick();
    menu_on = 1; pixel(410, 310);
    checks++;
    if (hit !== 1'b0 || hp !== 4'd5 || invulnerable !== 1'b0)
      $display("FAIL abort got hit=%b hp=%0d inv=%b exp 0/5/0", hit, hp, invulnerable);
    else passed++;
    menu_on = 0; cycle();
  endtask

  task automatic test_origin();
    mouse_x = 0; mouse_y = 0; frame_tick();
    pixel(0, 0);
    checks++; if (hit !== 1'b0) $display("FAIL origin got hit=%b exp=0", hit); else passed++;
    pixel(1, 1);
    checks++; if (hit !== 1'b1) $display("FAIL near_origin got hit=%b exp=1", hit); else passed++;
    menu_on = 1; cycle(); menu_on = 0; cycle();
    mouse_x = 4090; mouse_y = 4090; frame_tick();
    pixel(5, 5);
    checks++; if (hit !== 1'b0) $display("FAIL no_wrap got hit=%b exp=0", hit); else passed++;
    pixel(4095, 4095);
    checks++; if (hit !== 1'b1) $display("FAIL far_corner got hit=%b exp=1", hit); else passed++;
  endtask

  task automatic test_random();
    int ox, oy;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      menu_on = ($urandom_range(0, 59) == 0);
      play_selected = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 3) == 0) begin
        hcount_in = 0; vcount_in = 0;
      end else begin
        hcount_in = 12'($urandom_range(1, 800)); vcount_in = 12'($urandom_range(0, 600));
      end
      if ($urandom_range(0, 7) == 0) begin
        mouse_x = ($urandom_range(0, 5) == 0) ? 12'($urandom_range(4080, 4095)) : 12'($urandom_range(0, 4095));
        mouse_y = 12'($urandom_range(0, 4095));
      end
      if ($urandom_range(0, 2) == 0) begin
        ox = 0; oy = 0;
      end else begin
        ox = lx + $urandom_range(0, 21) - 3; oy = ly + $urandom_range(0, 21) - 3;
        if (ox < 0) ox = 0; if (ox > 4095) ox = 4095;
        if (oy < 0) oy = 0; if (oy > 4095) oy = 4095;
      end
      obstacle_x = 12'(ox); obstacle_y = 12'(oy);
      cycle();
      checks++;
      if (hp !== 4'(m_hp)) $display("FAIL rand_hp cyc=%0d got=%0d exp=%0d", i, hp, m_hp); else passed++;
      checks++;
      if (hit !== m_hit) $display("FAIL rand_hit cyc=%0d got=%b exp=%b", i, hit, m_hit); else passed++;
      checks++;
      if (invulnerable !== (in_game && cool > 0))
        $display("FAIL rand_inv cyc=%0d got=%b exp=%b", i, invulnerable, (in_game && cool > 0));
      else passed++;
      checks++;
      if (game_over !== (in_game && m_hp == 0))
        $display("FAIL rand_go cyc=%0d got=%b exp=%b", i, game_over, (in_game && m_hp == 0));
      else passed++;
    end
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_first_hit();
    test_cooldown();
    test_death();
    test_mouse_latch();
    test_abort();
    test_origin();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
